// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: iterative HI/LO multiply, madd and msub unit with mthi/mtlo access
module hilo_mult_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [4:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] MulLo,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int N = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [4:0] OP_MULT = 5'd31;
  localparam logic [4:0] OP_MULTU = 5'd26;
  localparam logic [4:0] OP_MADD = 5'd30;
  localparam logic [4:0] OP_MSUB = 5'd29;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state;
  logic [4:0] op;
  logic neg;
  logic [2*WIDTH-1:0] mcand, p, pp, r, hilo;
  logic [WIDTH-1:0] mplier, abs_a, abs_b;
  logic [CW-1:0] count;
  logic valid_op, signed_op;
  // launch decode: signed ops work on magnitudes, the sign is reapplied at the end
  always_comb begin
    valid_op = ALUOp inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB};
    signed_op = ALUOp != OP_MULTU;
    abs_a = signed_op && A[WIDTH-1] ? -A : A;
    abs_b = signed_op && B[WIDTH-1] ? -B : B;
  end
  // partial product of this iteration and the final signed, accumulated HI/LO value
  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      pp = pp + (mplier[i] ? mcand << i : '0);
    r = neg ? -p : p;
    hilo = op == OP_MADD ? {Hi, Lo} + r : op == OP_MSUB ? {Hi, Lo} - r : r;
  end
  // control FSM, shift-add datapath and architectural HI/LO registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      Hi     <= '0;
      Lo     <= '0;
      MulLo  <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      op     <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      p      <= '0;
      count  <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (valid_op) begin
              op     <= ALUOp;
              neg    <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
              mcand  <= {{WIDTH{1'b0}}, abs_a};
              mplier <= abs_b;
              p      <= '0;
              count  <= '0;
              Busy   <= 1'b1;
              state  <= RUN;
            end
          end else begin
            if (HiWrite) Hi <= A;
            if (LoWrite) Lo <= A;
          end
        end
        RUN: begin
          p      <= p + pp;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          count  <= count + 1'b1;
          if (count == CW'(N - 1)) state <= FINISH;
        end
        FINISH: begin
          {Hi, Lo} <= hilo;
          MulLo    <= r[WIDTH-1:0];
          Done     <= 1'b1;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit: randomized self-checking bench against a 64-bit arithmetic model
module tb_hilo_mult_unit;
  logic Clk = 1'b0;
  logic Reset, Start, Start4, HiWrite, LoWrite;
  logic [4:0] ALUOp;
  logic [31:0] A, B;
  logic Busy, Done, Busy4, Done4;
  logic [31:0] MulLo, Hi, Lo, MulLo4, Hi4, Lo4;
  logic [63:0] m, m4, r;
  logic [4:0] ops [4] = '{5'd31, 5'd26, 5'd30, 5'd29};
  int errors = 0;
  int checks = 0;

  hilo_mult_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUOp(ALUOp), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .Busy(Busy), .Done(Done),
    .MulLo(MulLo), .Hi(Hi), .Lo(Lo)
  );

  hilo_mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start4), .ALUOp(ALUOp), .A(A), .B(B),
    .HiWrite(1'b0), .LoWrite(1'b0), .Busy(Busy4), .Done(Done4),
    .MulLo(MulLo4), .Hi(Hi4), .Lo(Lo4)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] product(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (op == 5'd26) return {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  function automatic logic [63:0] apply(input logic [4:0] op, input logic [63:0] old, input logic [63:0] prod);
    return op == 5'd30 ? old + prod : op == 5'd29 ? old - prod : prod;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(3))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  task automatic run(input bit d4, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input bit noise, output int lat, output bit busy_ok);
    if (d4) Start4 = 1'b1; else Start = 1'b1;
    ALUOp = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; Start4 = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    busy_ok = 1'b1; lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (noise && c == 3) begin
        Start = 1'b1; ALUOp = 5'd26; A = $urandom; B = $urandom; HiWrite = 1'b1; LoWrite = 1'b1;
      end
      if (noise && c == 6) begin
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      end
      @(posedge Clk); #1;
      if (d4 ? Done4 : Done) begin lat = c; break; end
      if (!(d4 ? Busy4 : Busy)) busy_ok = 1'b0;
    end
  endtask

  task automatic mt(input bit hw, input bit lw, input logic [31:0] a);
    HiWrite = hw; LoWrite = lw; A = a;
    @(posedge Clk); #1;
    HiWrite = 1'b0; LoWrite = 1'b0;
    if (hw) m[63:32] = a;
    if (lw) m[31:0] = a;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    m = '0; m4 = '0;
    checks++; if (Hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h exp 0", Hi); end
    checks++; if (Lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h exp 0", Lo); end
    checks++; if (MulLo !== 32'h0) begin errors++; $display("FAIL reset_mullo: got %h exp 0", MulLo); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", Done); end
  endtask

  task automatic test_vectors();
    int lat; bit bok;
    run(0, 5'd31, 32'hFFFF_FFFD, 32'd7, 0, lat, bok);
    checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency: got %0d exp 33", lat); end
    checks++; if (!bok) begin errors++; $display("FAIL mult_busy: got low exp high while running"); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b exp 0", Busy); end
    checks++; if ({Hi, Lo, MulLo} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB}) begin
      errors++; $display("FAIL mult_result: got %h %h %h exp ffffffff ffffffeb ffffffeb", Hi, Lo, MulLo); end
    run(0, 5'd26, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bok);
    checks++; if ({Hi, Lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL multu_result: got %h%h exp fffffffe00000001", Hi, Lo); end
    mt(1, 0, 32'd0);
    mt(0, 1, 32'd10);
    checks++; if ({Hi, Lo} !== 64'd10) begin errors++; $display("FAIL mthi_mtlo: got %h%h exp 10", Hi, Lo); end
    run(0, 5'd30, 32'd2, 32'd3, 0, lat, bok);
    checks++; if ({Hi, Lo} !== 64'd16) begin errors++; $display("FAIL madd_result: got %h%h exp 16", Hi, Lo); end
    run(0, 5'd29, 32'd4, 32'd5, 0, lat, bok);
    checks++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL msub_result: got %h%h exp fffffffffffffffc", Hi, Lo); end
    m = {Hi, Lo};
  endtask

  task automatic test_random();
    int lat; bit bok; logic [4:0] op; logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(3) == 0) mt($urandom_range(1) == 1, $urandom_range(1) == 1, $urandom);
      op = ops[$urandom_range(3)]; a = pick(); b = pick();
      run(0, op, a, b, 0, lat, bok);
      r = product(op, a, b); m = apply(op, m, r);
      checks++; if ({Hi, Lo} !== m) begin errors++; $display("FAIL rand_hilo %0d op %0d: got %h%h exp %h", i, op, Hi, Lo, m); end
      checks++; if (MulLo !== r[31:0]) begin errors++; $display("FAIL rand_mullo %0d: got %h exp %h", i, MulLo, r[31:0]); end
      checks++; if (lat != 33 || !bok) begin errors++; $display("FAIL rand_timing %0d: got lat %0d busy_ok %0b exp 33 1", i, lat, bok); end
    end
  endtask

  task automatic test_invalid_and_conflict();
    int lat; bit bok; bit seen;
    Start = 1'b1; ALUOp = 5'd3; A = 32'h1234_5678; B = 32'd9; HiWrite = 1'b1; LoWrite = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 36; c++) begin
      if (Busy || Done) seen = 1'b1;
      @(posedge Clk); #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL invalid_op: got busy/done activity exp none"); end
    checks++; if ({Hi, Lo} !== m) begin errors++; $display("FAIL invalid_write_dropped: got %h%h exp %h", Hi, Lo, m); end
    mt(1, 1, 32'h0000_0100);
    checks++; if ({Hi, Lo} !== 64'h0000_0100_0000_0100) begin errors++; $display("FAIL both_writes: got %h%h exp %h", Hi, Lo, 64'h0000_0100_0000_0100); end
    HiWrite = 1'b1; LoWrite = 1'b1;
    run(0, 5'd30, 32'd5, 32'hFFFF_FFFE, 0, lat, bok);
    m = apply(5'd30, m, product(5'd30, 32'd5, 32'hFFFF_FFFE));
    checks++; if ({Hi, Lo} !== m) begin errors++; $display("FAIL start_wins: got %h%h exp %h", Hi, Lo, m); end
  endtask

  task automatic test_run_ignores();
    int lat; bit bok;
    run(0, 5'd31, 32'hFFFF_FF00, 32'd1000, 1, lat, bok);
    m = product(5'd31, 32'hFFFF_FF00, 32'd1000);
    checks++; if ({Hi, Lo} !== m || lat != 33) begin
      errors++; $display("FAIL run_ignores: got %h%h lat %0d exp %h lat 33", Hi, Lo, lat, m); end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    run(0, 5'd26, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, lat, bok);
    m = product(5'd26, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    checks++; if (Done !== 1'b1 || {Hi, Lo} !== m) begin
      errors++; $display("FAIL b2b_first: got done %b %h%h exp 1 %h", Done, Hi, Lo, m); end
    run(0, 5'd29, 32'h7FFF_FFFF, 32'h8000_0000, 0, lat, bok);
    m = apply(5'd29, m, product(5'd29, 32'h7FFF_FFFF, 32'h8000_0000));
    checks++; if ({Hi, Lo} !== m || lat != 33) begin
      errors++; $display("FAIL b2b_second: got %h%h lat %0d exp %h lat 33", Hi, Lo, lat, m); end
    @(posedge Clk); #1;
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse: got done %b busy %b exp 0 0", Done, Busy); end
  endtask

  task automatic test_reset_mid();
    int lat; bit bok; bit seen;
    Start = 1'b1; ALUOp = 5'd31; A = 32'd123; B = 32'd456;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    m = '0;
    checks++; if (Busy !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
      errors++; $display("FAIL reset_mid: got busy %b %h%h exp 0 0", Busy, Hi, Lo); end
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clk); #1;
      if (Done || Busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL reset_mid_abandon: got busy/done activity exp none"); end
    run(0, 5'd31, 32'd6, 32'd7, 0, lat, bok);
    checks++; if ({Hi, Lo} !== 64'd42) begin errors++; $display("FAIL after_reset_mult: got %h%h exp 42", Hi, Lo); end
  endtask

  task automatic test_bpc4();
    int lat; bit bok; logic [4:0] op; logic [31:0] a, b;
    run(1, 5'd31, 32'h8000_0000, 32'h8000_0000, 0, lat, bok);
    checks++; if (lat != 9 || !bok) begin errors++; $display("FAIL bpc4_timing: got lat %0d busy_ok %0b exp 9 1", lat, bok); end
    checks++; if ({Hi4, Lo4, MulLo4} !== {32'h4000_0000, 32'h0, 32'h0}) begin
      errors++; $display("FAIL bpc4_result: got %h %h %h exp 40000000 0 0", Hi4, Lo4, MulLo4); end
    m4 = 64'h4000_0000_0000_0000;
    for (int i = 0; i < 8; i++) begin
      op = ops[$urandom_range(3)]; a = pick(); b = pick();
      run(1, op, a, b, 0, lat, bok);
      r = product(op, a, b); m4 = apply(op, m4, r);
      checks++; if ({Hi4, Lo4} !== m4 || MulLo4 !== r[31:0] || lat != 9) begin
        errors++; $display("FAIL bpc4_rand %0d op %0d: got %h%h %h lat %0d exp %h %h 9", i, op, Hi4, Lo4, MulLo4, lat, m4, r[31:0]); end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Start4 = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    ALUOp = '0; A = '0; B = '0;
    @(posedge Clk); #1;
    test_reset();
    test_vectors();
    test_random();
    test_invalid_and_conflict();
    test_run_ignores();
    test_back_to_back();
    test_reset_mid();
    test_bpc4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
